rbcp_reg_bank: RTL and testbench

Parametrised RBCP local register file: the generic successor of the fixed-map test register block. It decodes one 64 KiB page of the RBCP LOC_* bus and provides N_REG byte registers. Each byte is individually configured as read/write, read-only status, sticky write-one-to-clear status, or write-pulse. It sits between SiTCP-XG RBCP and user logic, and can be instanced once per page.

---
 rtl/rbcp_reg_bank.sv | 165 ++++++++++++++++
 tb/tb_rbcp_reg_bank.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rbcp_reg_bank.sv
// rtl/rbcp_reg_bank.sv - parametrised RBCP byte register page (RW / RO / sticky W1C / pulse)
// Four-stage access pipeline; a single skid entry absorbs the write/read ACK collision.
module rbcp_reg_bank #(
  parameter int                 N_REG      = 32,
  parameter logic [15:0]        ADDR_PAGE  = 16'h0000,
  parameter logic [N_REG-1:0]   RO_MASK    = '0,
  parameter logic [N_REG-1:0]   STKY_MASK  = '0,
  parameter logic [N_REG-1:0]   PULSE_MASK = '0,
  parameter logic [8*N_REG-1:0] RST_VAL    = '0
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic [31:0]        LOC_ADDR,
  input  logic               LOC_WE,
  input  logic [7:0]         LOC_WD,
  input  logic               LOC_RE,
  output logic               LOC_ACK,
  output logic [7:0]         LOC_RD,
  input  logic [8*N_REG-1:0] STS_IN,
  output logic [8*N_REG-1:0] REG_OUT,
  output logic [8*N_REG-1:0] PULSE_OUT
);

  localparam int AW = $clog2(N_REG);
  localparam int DW = 8 * N_REG;

  function automatic logic [DW-1:0] expand(input logic [N_REG-1:0] m);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N_REG; i++) r[8*i +: 8] = {8{m[i]}};
    return r;
  endfunction

  // Resolve overlapping masks once: RO > STKY > PULSE > RW.
  localparam logic [N_REG-1:0] RO_M    = RO_MASK;
  localparam logic [N_REG-1:0] STKY_M  = STKY_MASK & ~RO_MASK;
  localparam logic [N_REG-1:0] PULSE_M = PULSE_MASK & ~STKY_MASK & ~RO_MASK;
  localparam logic [N_REG-1:0] RW_M    = ~(RO_M | STKY_M | PULSE_M);
  localparam logic [DW-1:0]    RW_BYTES = expand(RW_M);

  logic          s1_vld_q, s1_vld_d, s1_we_q, s1_we_d, s1_oob_q, s1_oob_d;
  logic [AW-1:0] s1_idx_q, s1_idx_d;
  logic [7:0]    s1_wd_q, s1_wd_d;
  logic          s2_vld_q, s2_vld_d, s2_oob_q, s2_oob_d;
  logic [AW-1:0] s2_idx_q, s2_idx_d;
  logic [7:0]    s2_sts_q, s2_sts_d;
  logic          s3_vld_q, s3_vld_d;
  logic [7:0]    s3_data_q, s3_data_d;
  logic          skid_vld_q, skid_vld_d;
  logic [7:0]    skid_data_q, skid_data_d;
  logic          ack_q, ack_d;
  logic [7:0]    rd_q, rd_d;
  logic [DW-1:0] rw_q, rw_d, stky_q, stky_d, pulse_q, pulse_d;
  logic          wr_commit, wr_ack;

  always_comb begin
    s1_vld_d = (LOC_ADDR[31:16] == ADDR_PAGE) && (LOC_WE || LOC_RE);
    s1_we_d  = LOC_WE;
    s1_oob_d = LOC_ADDR[15:0] >= 16'(N_REG);
    s1_idx_d = LOC_ADDR[AW-1:0];
    s1_wd_d  = LOC_WD;

    // A combined WE/RE strobe is treated purely as a write.
    s2_vld_d = s1_vld_q && !s1_we_q;
    s2_oob_d = s1_oob_q;
    s2_idx_d = s1_idx_q;
    s2_sts_d = STS_IN[{s1_idx_q, 3'b000} +: 8];

    s3_vld_d = s2_vld_q;
    if (s2_oob_q)                s3_data_d = 8'h00;
    else if (RO_M[s2_idx_q])     s3_data_d = s2_sts_q;
    else if (STKY_M[s2_idx_q])   s3_data_d = stky_q[{s2_idx_q, 3'b000} +: 8];
    else if (PULSE_M[s2_idx_q])  s3_data_d = 8'h00;
    else                         s3_data_d = rw_q[{s2_idx_q, 3'b000} +: 8];
  end

  always_comb begin
    wr_commit = s1_vld_q && s1_we_q && !s1_oob_q;
    rw_d      = rw_q;
    stky_d    = '0;
    pulse_d   = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (wr_commit && s1_idx_q == AW'(i)) begin
        if (RW_M[i])    rw_d[8*i +: 8]    = s1_wd_q;
        if (PULSE_M[i]) pulse_d[8*i +: 8] = s1_wd_q;
      end
      // Set has priority over a coincident clear.
      if (STKY_M[i])
        stky_d[8*i +: 8] = (stky_q[8*i +: 8] &
                            ~((wr_commit && s1_idx_q == AW'(i)) ? s1_wd_q : 8'h00)) |
                           STS_IN[8*i +: 8];
    end
  end

  always_comb begin
    wr_ack      = s1_vld_q && s1_we_q;
    ack_d       = 1'b0;
    rd_d        = 8'h00;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (wr_ack) begin
      ack_d = 1'b1;
      if (s3_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = s3_data_q;
      end
    end else if (skid_vld_q) begin
      ack_d       = 1'b1;
      rd_d        = skid_data_q;
      skid_vld_d  = s3_vld_q;
      skid_data_d = s3_data_q;
    end else if (s3_vld_q) begin
      ack_d = 1'b1;
      rd_d  = s3_data_q;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_vld_q    <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_oob_q    <= 1'b0;
      s1_idx_q    <= '0;
      s1_wd_q     <= 8'h00;
      s2_vld_q    <= 1'b0;
      s2_oob_q    <= 1'b0;
      s2_idx_q    <= '0;
      s2_sts_q    <= 8'h00;
      s3_vld_q    <= 1'b0;
      s3_data_q   <= 8'h00;
      skid_vld_q  <= 1'b0;
      skid_data_q <= 8'h00;
      ack_q       <= 1'b0;
      rd_q        <= 8'h00;
      rw_q        <= RST_VAL & RW_BYTES;
      stky_q      <= '0;
      pulse_q     <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_we_q     <= s1_we_d;
      s1_oob_q    <= s1_oob_d;
      s1_idx_q    <= s1_idx_d;
      s1_wd_q     <= s1_wd_d;
      s2_vld_q    <= s2_vld_d;
      s2_oob_q    <= s2_oob_d;
      s2_idx_q    <= s2_idx_d;
      s2_sts_q    <= s2_sts_d;
      s3_vld_q    <= s3_vld_d;
      s3_data_q   <= s3_data_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      ack_q       <= ack_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      stky_q      <= stky_d;
      pulse_q     <= pulse_d;
    end
  end

  assign LOC_ACK   = ack_q;
  assign LOC_RD    = rd_q;
  assign REG_OUT   = rw_q;
  assign PULSE_OUT = pulse_q;

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// tb/tb_rbcp_reg_bank.sv - directed bench with cycle-stamped ACK scoreboard
module tb_rbcp_reg_bank;

  localparam int         N_REG = 32;
  localparam int         DW    = 8 * N_REG;
  localparam logic [DW-1:0] RST_V = 256'h0D00;

  logic          CLK, RSTn;
  logic [31:0]   LOC_ADDR;
  logic          LOC_WE, LOC_RE, LOC_ACK;
  logic [7:0]    LOC_WD, LOC_RD;
  logic [DW-1:0] STS_IN, REG_OUT, PULSE_OUT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] exp_out;
  logic [DW-1:0] exp_pulse;

  rbcp_reg_bank #(
    .N_REG(N_REG), .ADDR_PAGE(16'h0000),
    .RO_MASK(32'h0000_0044), .STKY_MASK(32'h0000_00D0),
    .PULSE_MASK(32'h0000_00A0), .RST_VAL(RST_V)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .LOC_ADDR(LOC_ADDR), .LOC_WE(LOC_WE), .LOC_WD(LOC_WD),
    .LOC_RE(LOC_RE), .LOC_ACK(LOC_ACK), .LOC_RD(LOC_RD), .STS_IN(STS_IN),
    .REG_OUT(REG_OUT), .PULSE_OUT(PULSE_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // A write ACK landing on a pending read ACK pushes that read one cycle later.
  function automatic void push_exp(input int c, input logic [7:0] d, input bit is_wr);
    exp_t e;
    int   pos;
    e.cyc  = c;
    e.data = d;
    if (is_wr)
      foreach (sbq[i]) if (sbq[i].cyc == c) sbq[i].cyc = c + 1;
    pos = 0;
    while (pos < sbq.size() && sbq[pos].cyc <= c) pos++;
    sbq.insert(pos, e);
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (LOC_ACK === 1'b1) begin
      n_tests++;
      assert (sbq.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_ack: cycle %0d rd %02h, required no ACK", cyc, LOC_RD);
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        n_tests += 2;
        assert (cyc === e.cyc) else begin
          n_fail++;
          $error("FAIL ack_cycle: observed %0d, expected %0d", cyc, e.cyc);
        end
        assert (LOC_RD === e.data) else begin
          n_fail++;
          $error("FAIL ack_data: cycle %0d observed %02h, expected %02h", cyc, LOC_RD, e.data);
        end
      end
    end else begin
      n_tests++;
      assert (LOC_ACK === 1'b0 && LOC_RD === 8'h00) else begin
        n_fail++;
        $error("FAIL idle_rd: cycle %0d observed ack %b rd %02h, expected 0/00", cyc, LOC_ACK, LOC_RD);
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic access(input logic we, input logic re, input logic [31:0] a,
                        input logic [7:0] wd, input bit want_ack, input logic [7:0] exp_rd);
    LOC_WE   = we;
    LOC_RE   = re;
    LOC_ADDR = a;
    LOC_WD   = wd;
    if (want_ack) push_exp(cyc + (we ? 2 : 4), we ? 8'h00 : exp_rd, we);
    idle(1);
    LOC_WE = 1'b0;
    LOC_RE = 1'b0;
    LOC_WD = 8'h00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    access(1'b1, 1'b0, a, d, 1'b1, 8'h00);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    access(1'b0, 1'b1, a, 8'h00, 1'b1, exp);
  endtask

  initial begin
    RSTn = 1'b0; LOC_ADDR = '0; LOC_WE = 1'b0; LOC_RE = 1'b0; LOC_WD = '0; STS_IN = '0;
    exp_out = RST_V;
    exp_pulse = '0;
    idle(3);
    RSTn = 1'b1;
    idle(1);
    chk("reset_reg_out", REG_OUT, exp_out);
    chk("reset_pulse_out", PULSE_OUT, '0);
    chk("reset_ack_rd", {247'd0, LOC_ACK, LOC_RD}, '0);

    rd(32'h0000_0001, 8'h0D);
    idle(5);

    wr(32'h0000_0003, 8'h5A);
    chk("rw_not_yet_cycle1", REG_OUT, exp_out);
    idle(1);
    exp_out[31:24] = 8'h5A;
    chk("rw_update_cycle2", REG_OUT, exp_out);
    rd(32'h0000_0003, 8'h5A);
    idle(5);

    STS_IN[23:16] = 8'hC3;
    idle(1);
    rd(32'h0000_0002, 8'hC3);
    idle(5);
    wr(32'h0000_0002, 8'hFF);
    idle(2);
    chk("ro_write_ignored", REG_OUT, exp_out);
    rd(32'h0000_0002, 8'hC3);
    idle(5);

    STS_IN[32] = 1'b1;
    idle(1);
    STS_IN[32] = 1'b0;
    rd(32'h0000_0004, 8'h01);
    idle(5);
    STS_IN[32] = 1'b1;
    wr(32'h0000_0004, 8'h01);
    idle(2);
    STS_IN[32] = 1'b0;
    rd(32'h0000_0004, 8'h01);
    idle(5);
    wr(32'h0000_0004, 8'h01);
    idle(2);
    rd(32'h0000_0004, 8'h00);
    idle(5);

    wr(32'h0000_0005, 8'h81);
    chk("pulse_cycle1", PULSE_OUT, '0);
    idle(1);
    exp_pulse[47:40] = 8'h81;
    chk("pulse_cycle2", PULSE_OUT, exp_pulse);
    idle(1);
    chk("pulse_cycle3", PULSE_OUT, '0);
    rd(32'h0000_0005, 8'h00);
    idle(5);

    STS_IN[55:48] = 8'h5A;
    idle(1);
    STS_IN[55:48] = 8'h00;
    rd(32'h0000_0006, 8'h00);
    wr(32'h0000_0007, 8'h81);
    idle(1);
    chk("stky_over_pulse", PULSE_OUT, '0);
    idle(5);

    access(1'b0, 1'b1, 32'h0001_0003, 8'h00, 1'b0, 8'h00);
    access(1'b1, 1'b0, 32'h0001_0003, 8'h77, 1'b0, 8'h00);
    idle(5);
    chk("nonhit_no_write", REG_OUT, exp_out);
    rd(32'h0000_0040, 8'h00);
    wr(32'h0000_0040, 8'hEE);
    idle(5);
    chk("oob_no_write", REG_OUT, exp_out);

    access(1'b1, 1'b1, 32'h0000_0000, 8'h33, 1'b1, 8'h00);
    idle(5);
    exp_out[7:0] = 8'h33;
    chk("we_re_write_done", REG_OUT, exp_out);

    wr(32'h0000_0000, 8'h11);
    rd(32'h0000_0000, 8'h11);
    rd(32'h0000_0001, 8'h0D);
    rd(32'h0000_0003, 8'h5A);
    idle(6);
    exp_out[7:0] = 8'h11;
    chk("b2b_reg_out", REG_OUT, exp_out);

    rd(32'h0000_0001, 8'h0D);
    idle(1);
    wr(32'h0000_0000, 8'h44);
    idle(6);
    exp_out[7:0] = 8'h44;
    chk("collision_reg_out", REG_OUT, exp_out);

    rd(32'h0000_0001, 8'h0D);
    sbq.pop_back();
    access(1'b1, 1'b0, 32'h0000_0003, 8'h99, 1'b0, 8'h00);
    RSTn = 1'b0;
    idle(2);
    RSTn = 1'b1;
    idle(6);
    exp_out = RST_V;
    chk("reset_mid_access", REG_OUT, exp_out);

    idle(4);
    chk("scoreboard_drained", DW'(sbq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
